// File: rtl/rca_seq_adder.sv
// rca_seq_adder: WIDTH-bit adder that reuses one external 3-bit ripple-carry slice over NSLICE cycles.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready     : result handshake (out_sum, out_cout)
//   busy                    : high while slices are being added
//   rca_a/rca_b/rca_cin     : drive the external slice adder
//   rca_sum/rca_cout        : combinational result of the external slice adder
// Optional: define RCA_SEQ_OVF_EN to add out_ovf (signed two's-complement overflow).
module rca_seq_adder #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef RCA_SEQ_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy,
    output logic [2:0]       rca_a,
    output logic [2:0]       rca_b,
    output logic             rca_cin,
    input  logic [2:0]       rca_sum,
    input  logic             rca_cout
);
    localparam int NSLICE = WIDTH / 3;
    localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;

    if (WIDTH % 3 != 0 || WIDTH < 3) begin : g_bad_width
        $error("rca_seq_adder: WIDTH must be a positive multiple of 3");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [WIDTH-1:0] op_a, op_b, sum_r;
    logic            cout_r;
    logic            last;

    assign last     = idx == IW'(NSLICE - 1);
    assign out_sum  = sum_r;
    assign out_cout = cout_r;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        rca_a     = 3'b0;
        rca_b     = 3'b0;
        rca_cin   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                rca_a   = op_a[3*idx +: 3];
                rca_b   = op_b[3*idx +: 3];
                rca_cin = carry;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            op_a  <= in_a;
            op_b  <= in_b;
            carry <= in_cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_r[3*idx +: 3] <= rca_sum;
            carry <= rca_cout;
            // wrap instead of incrementing past the last slice
            idx   <= last ? '0 : idx + 1'b1;
            if (last) cout_r <= rca_cout;
        end

`ifdef RCA_SEQ_OVF_EN
    logic ovf_r;
    assign out_ovf = ovf_r;
    // the top result bit is rca_sum[2] on the final slice, so overflow is captured on that same edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                 ovf_r <= 1'b0;
        else if (state == RUN && last)
            ovf_r <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (rca_sum[2] != op_a[WIDTH-1]);
`endif
endmodule

// File: tb/tb_rca_seq_adder.sv
// tb_rca_seq_adder: directed and randomized checks of rca_seq_adder driving a modelled 3-bit slice adder.
module tb_rca_seq_adder;
    localparam int WIDTH = 12;
    localparam int NSLICE = WIDTH / 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef RCA_SEQ_OVF_EN
    logic             out_ovf;
`endif
    logic             busy;
    logic [2:0]       rca_a, rca_b, rca_sum;
    logic             rca_cin, rca_cout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // the external 3-bit ripple-carry slice
    assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {3'b0, rca_cin};

    rca_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
`ifdef RCA_SEQ_OVF_EN
        .out_ovf(out_ovf),
`endif
        .busy(busy),
        .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
        .rca_sum(rca_sum), .rca_cout(rca_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one full operation; poke drives a stray 0x111+0x111 operand during the stall window
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                         input int stall, input logic poke, input logic [WIDTH:0] exp);
        logic [WIDTH:0] m, c;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~cin;
        for (int k = 0; k < NSLICE; k++) begin
            m = ((WIDTH+1)'(1) << (3*k)) - 1'b1;
            c = (({1'b0, a} & m) + ({1'b0, b} & m) + {{WIDTH{1'b0}}, cin}) >> (3*k);
            check("busy_run", busy, 1);
            check("in_ready_run", in_ready, 0);
            check("out_valid_run", out_valid, 0);
            check("rca_a", rca_a, 3'(a >> (3*k)));
            check("rca_b", rca_b, 3'(b >> (3*k)));
            check("rca_cin", rca_cin, c[0]);
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("out_valid", out_valid, 1);
        check("busy_done", busy, 0);
        check("out_sum", out_sum, exp[WIDTH-1:0]);
        check("out_cout", out_cout, exp[WIDTH]);
        check("rca_a_done", {rca_a, rca_b, rca_cin}, 0);
`ifdef RCA_SEQ_OVF_EN
        check("out_ovf", out_ovf, (a[WIDTH-1] == b[WIDTH-1]) && (exp[WIDTH-1] != a[WIDTH-1]));
`endif
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                in_valid = 1'b1; in_a = 12'h111; in_b = 12'h111; in_cin = 1'b0;
            end
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, exp[WIDTH-1:0]);
            check("hold_cout", out_cout, exp[WIDTH]);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after", out_valid, 0);
        check("in_ready_after", in_ready, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out", {out_sum, out_cout}, 0);
        check("rst_rca", {rca_a, rca_b, rca_cin}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(12'hABC, 12'h123, 1'b1, 0, 1'b0, 13'h0BE0);
        do_op(12'hFFF, 12'h000, 1'b1, 0, 1'b0, 13'h1000);
        do_op(12'h7FF, 12'h001, 1'b0, 0, 1'b0, 13'h0800);
        do_op(12'h005, 12'h003, 1'b0, 6, 1'b1, 13'h0008);
        do_op(12'h111, 12'h111, 1'b0, 0, 1'b0, 13'h0222);

        // abort two cycles into a run
        @(negedge clk);
        in_a = 12'hFFF; in_b = 12'hFFF; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_partial_sum", out_sum != 0, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out", {out_valid, out_sum, out_cout}, 0);
        check("abort_rca", {rca_a, rca_b, rca_cin}, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        do_op(12'h001, 12'h001, 1'b0, 0, 1'b0, 13'h0002);

        for (int i = 0; i < 20; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'b0, {1'b0, ra} + {1'b0, rb} + {12'b0, rc});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
